// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: the hex glyph table
// and the "everything dark" patterns for cathodes and anodes.
package seg7_pkg;

    // All segments off (cathodes are active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // All anodes off (anodes are active-low).
    localparam logic [7:0] AN_OFF = 8'hFF;

    // Hex glyphs 0..F, bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder, usable by any display driver.
module seg7_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    // Table lookup into the shared glyph ROM.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_frame_scanner.sv
// Eight-digit multiplexed seven-segment scanner. The displayed word is
// captured once per frame so a value changing mid-scan is never torn across
// digits; each digit slot begins with anode-off guard clocks to stop ghosting.
// The scan state is {started, idx, cnt}: started=0 means "waiting for the
// first frame boundary", idx is the digit slot, cnt is the position in it.
module seg7_frame_scanner #(
    parameter int unsigned REFRESH_DIV = 131072,
    parameter int unsigned BLANK_CYC   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        dp,
    output logic        frame_done
);
    import seg7_pkg::*;

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          started;
    logic [31:0]   snap_data;
    logic [7:0]    snap_dp;
    logic          snap_lz;

    logic          tick;
    logic          frame_edge;
    logic [4:0]    shamt;
    logic [31:0]   upper;
    logic          lz_hide;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    logic          vis;

    // Slot boundary strobe and whether it also closes a frame.
    always_comb begin
        tick       = en && (cnt == CNT_LAST);
        frame_edge = tick && (!started || (idx == 3'd7));
    end

    // Visibility of the current digit: guard window and leading-zero blanking.
    // Digit i is a leading zero when every nibble from i upward is zero;
    // digit 0 is always shown so a zero value still reads "0".
    always_comb begin
        shamt   = {idx, 2'b00};
        upper   = snap_data >> shamt;
        lz_hide = snap_lz && (idx != 3'd0) && (upper == 32'd0);
        nib     = snap_data[shamt +: 4];
        vis     = en && started && (32'(cnt) >= BLANK_CYC) && !lz_hide;
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nib),
        .seg    (dec_seg)
    );

    // Prescaler, digit index and once-per-frame snapshot of the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= 3'd0;
            started   <= 1'b0;
            snap_data <= 32'd0;
            snap_dp   <= 8'd0;
            snap_lz   <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            idx     <= 3'd0;
            started <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (frame_edge) begin
                idx       <= 3'd0;
                started   <= 1'b1;
                snap_data <= data_in;
                snap_dp   <= dp_mask;
                snap_lz   <= blank_lz;
            end else if (tick) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Registered display drive; dark whenever the digit is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= vis ? ~(8'b1 << idx) : AN_OFF;
            seg        <= vis ? dec_seg : SEG_OFF;
            dp         <= vis ? ~snap_dp[idx] : 1'b1;
            frame_done <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg7_frame_scanner.sv
// Bench for seg7_frame_scanner: one instance at REFRESH_DIV=8/BLANK_CYC=2
// checked cycle by cycle against a slot-arithmetic model, and a second
// instance at REFRESH_DIV=4/BLANK_CYC=3 for the one-lit-clock-per-slot case.
module tb_seg7_frame_scanner;

    localparam int RD  = 8;
    localparam int BC  = 2;
    localparam int RD1 = 4;
    localparam int BC1 = 3;
    localparam int W   = 17;   // {an, seg, dp, frame_done}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg, seg1;
    logic [7:0]  an, an1;
    logic        dp, dp1, fd, fd1;

    // Clock and reset block: 10 ns clock, reset held until released below.
    always #5 clk = ~clk;

    seg7_frame_scanner #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_done (fd)
    );

    seg7_frame_scanner #(.REFRESH_DIV(RD1), .BLANK_CYC(BC1)) u_dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .seg        (seg1),
        .an         (an1),
        .dp         (dp1),
        .frame_done (fd1)
    );

    int          checks = 0;
    int          failures = 0;
    int          n = 0;            // clock edges since the scan restarted
    logic [W-1:0] exp_q[$];
    logic [31:0] m_sd = 32'd0;     // model snapshot
    logic [7:0]  m_sp = 8'd0;
    logic        m_sl = 1'b0;
    logic [7:0]  lit_mask = 8'd0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dpm;
        logic        lz;
        logic [7:0]  lit;          // digits expected to light during a frame
    } vec_t;

    vec_t vecs[6];

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected outputs right after edge nn of a scan that started at nn=0.
    // They reflect the state left by edge nn-1: the first RD edges only
    // count up, then each slot is rd clocks, the first bc of them dark.
    function automatic logic [W-1:0] model_out(input int nn, input int rd, input int bc,
                                               input logic [31:0] sd, input logic [7:0] sp,
                                               input logic sl);
        int j, t, pos, slot;
        logic [7:0] a;
        logic [6:0] s;
        logic d, fdx;
        a = 8'hFF;
        s = 7'h7F;
        d = 1'b1;
        fdx = (nn >= rd) && (((nn - rd) % (8 * rd)) == 0);
        j = nn - 1;
        if (j >= rd) begin
            t = j - rd;
            pos = t % rd;
            slot = (t / rd) % 8;
            if (pos >= bc && !(sl && slot != 0 && (sd >> (4 * slot)) == 32'd0)) begin
                a = ~(8'h01 << slot);
                s = hexseg(sd[4 * slot +: 4]);
                d = ~sp[slot];
            end
        end
        return {a, s, d, fdx};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
        end
    endtask

    // Driver + scoreboard: push the expectation for the next edge, then pop
    // and compare once the DUT has produced it (sampled on the falling edge).
    task automatic step();
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (!en) begin
            n = 0;
            e = {8'hFF, 7'h7F, 1'b1, 1'b0};
        end else begin
            n++;
            e = model_out(n, RD, BC, m_sd, m_sp, m_sl);
            if (n >= RD && ((n - RD) % (8 * RD)) == 0) begin
                m_sd = data_in;
                m_sp = dp_mask;
                m_sl = blank_lz;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        got = {an, seg, dp, fd};
        if (an != 8'hFF) lit_mask |= ~an;
        e = exp_q.pop_front();
        check("scan", got, e);
    endtask

    // One en-low edge restarts the scan from scratch.
    task automatic restart();
        en = 1'b0;
        step();
        en = 1'b1;
        lit_mask = 8'd0;
    endtask

    initial begin
        int fd_at;
        int lit1;
        logic [W-1:0] e1;

        vecs[0] = '{data: 32'h1234ABCD, dpm: 8'h00, lz: 1'b0, lit: 8'hFF};
        vecs[1] = '{data: 32'h000000A0, dpm: 8'h00, lz: 1'b1, lit: 8'h03};
        vecs[2] = '{data: 32'h00000000, dpm: 8'h00, lz: 1'b1, lit: 8'h01};
        vecs[3] = '{data: 32'h1234ABCD, dpm: 8'h81, lz: 1'b0, lit: 8'hFF};
        vecs[4] = '{data: 32'h00F00000, dpm: 8'h5A, lz: 1'b1, lit: 8'h3F};
        vecs[5] = '{data: $urandom(), dpm: 8'($urandom_range(0, 255)), lz: 1'b0, lit: 8'hFF};

        // Reset state of both instances.
        #12;
        check("reset_out", {an, seg, dp, fd}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        check("reset_out_fast", {an1, seg1, dp1, fd1}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one full frame per vector, compared every clock.
        for (int v = 0; v < 6; v++) begin
            data_in  = vecs[v].data;
            dp_mask  = vecs[v].dpm;
            blank_lz = vecs[v].lz;
            restart();
            repeat (RD + 8 * RD) step();
            check("lit_digits", {9'd0, lit_mask}, {9'd0, vecs[v].lit});
        end

        // Anti-tear: data changes during slot 3 of the first frame.
        data_in  = 32'h1234ABCD;
        dp_mask  = 8'h00;
        blank_lz = 1'b0;
        restart();
        repeat (35) step();
        data_in = 32'hFFFFFFFF;
        repeat (110) begin
            step();
            if (n == 69)  check("antitear_old_d7", {10'd0, seg}, {10'd0, 7'b1111001});
            if (n == 133) check("antitear_new_d7", {10'd0, seg}, {10'd0, 7'b0001110});
        end

        // en dropped for one edge in slot 5; the next frame_done is RD edges out.
        data_in = 32'h1234ABCD;
        restart();
        repeat (52) step();
        en = 1'b0;
        step();
        check("en_drop_dark", {9'd0, an}, {9'd0, 8'hFF});
        en = 1'b1;
        fd_at = -1;
        for (int k = 1; k <= RD + 12; k++) begin
            step();
            if (fd && fd_at < 0) fd_at = k;
        end
        check("en_restart_fd", W'(fd_at), W'(RD));

        // Short slots: REFRESH_DIV=4, BLANK_CYC=3 gives one lit clock per slot.
        data_in = 32'h87654321;
        dp_mask = 8'h10;
        restart();
        lit1 = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            e1 = model_out(k, RD1, BC1, data_in, dp_mask, blank_lz);
            check("fast_scan", {an1, seg1, dp1, fd1}, e1);
            if (k >= 5 && k <= 36 && an1 != 8'hFF) lit1++;
        end
        check("fast_lit_count", W'(lit1), W'(8));

        // Asynchronous reset while a digit is lit.
        data_in = 32'h1234ABCD;
        dp_mask = 8'hFF;
        restart();
        repeat (20) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {an, seg, dp, fd}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        check("async_reset_fast", {an1, seg1, dp1, fd1}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (RD + 16) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_frame_scanner.md
Name: seg7_frame_scanner

Overview:
- Drives the board's 8-digit multiplexed seven-segment display from a 32-bit word (register-file or memory data chosen upstream).
- Sits directly downstream of the register/memory read-out path.
- Snapshots the input once per frame so a value changing mid-scan never shows as a torn number.
- Inserts anode-off guard cycles between digits to suppress ghosting, and supports leading-zero blanking and per-digit decimal points.

Parameters:
- REFRESH_DIV, 131072: clocks per digit slot; 100 MHz gives about 95 Hz per frame. Legal range 4..2^24.
- BLANK_CYC, 1024: clocks at the start of each slot with all anodes off. Must be less than REFRESH_DIV.

Ports:
- clk  in  1  system clock, same domain as the display clock from clkdiv
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 turns the display dark and restarts the scan
- data_in  in  32  value to show; nibble i appears on digit i (digit 7 is leftmost)
- dp_mask  in  8  bit i = 1 lights the decimal point of digit i
- blank_lz  in  1  1 enables leading-zero blanking
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- an  out  8  anodes, active-low, one-hot-low when lit
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-clock pulse on each snapshot load

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, idx=0, started=0, snap_data=0, snap_dp=0, snap_lz=0.
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps while en=1.
  - tick = en && (cnt==REFRESH_DIV-1).
- Digit index and snapshot, evaluated on tick:
  - If started=0 or idx==7: idx<=0, started<=1, and snap_data/snap_dp/snap_lz <= data_in/dp_mask/blank_lz. frame_done<=1 for exactly one cycle.
  - Otherwise: idx<=idx+1.
- The first lit digit therefore appears REFRESH_DIV clocks after en rises. The snapshot is only ever loaded at that frame boundary.
- en=0:
  - Synchronously: cnt<=0, idx<=0, started<=0.
  - Snapshot is held; outputs forced dark from the next cycle.
  - Re-asserting en restarts exactly as after reset.
- Digit visibility (combinational in D, then registered):
  - vis = started && cnt>=BLANK_CYC && !lz_blank(idx).
  - lz_blank(i) = snap_lz && i!=0 && snap_data[31:4*i]==0. Digit 0 is always shown.
- Output decode when vis:
  - an = ~(8'b1<<idx).
  - seg = hex map of snap_data[4*idx+:4].
  - dp = ~snap_dp[idx].
- Output decode when not vis: an=8'hFF, seg=7'h7F, dp=1. A blanked digit's dp is also dark.
- Latency: an/seg/dp/frame_done are registered, so they reflect state one clock after the cnt/idx/snap values that produced them.
- Hex map (gfedcba, active-low), 0..F:
  - 0..7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
  - 8..F: 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Reset mid-frame: outputs go dark immediately (asynchronously). No partial-frame state survives.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF=7'h7F and AN_OFF=8'hFF.
- One combinational sub-module, seg7_hex_decode (4-bit nibble in, 7-bit seg out), shared with any other display users.
- Prescaler, index, snapshot, blanking and output registers stay in seg7_frame_scanner.

Test Plan (REFRESH_DIV=8, BLANK_CYC=2 unless stated):
- Reset then en=1, data_in=32'h1234ABCD, dp_mask=0, blank_lz=0:
  - frame_done pulses at clock 8.
  - Per slot, an shows 2 dark clocks then digits 0..7 in order.
  - Seg values: D=0100001, C=1000110, B=0000011, A=0001000, 4, 3, 2, 1.
  - Frame period is 64 clocks.
- Anti-tear: change data_in to 32'hFFFFFFFF during slot 3 → slots 4..7 still show 4,3,2,1; the next frame shows F on all digits.
- Leading-zero blanking with blank_lz=1:
  - data_in=32'h0000_00A0 → only digits 1 (A) and 0 (0) ever light; an stays 8'hFF during slots 2..7.
  - data_in=0 → only digit 0 shows 0.
- dp_mask=8'h81 → dp=0 only while digit 0 and digit 7 are lit, and never during guard cycles.
- Drop en for one cycle in slot 5:
  - an=8'hFF on the following cycle.
  - After en returns, the next frame_done comes 8 clocks later with idx=0.
- Assert rst_n=0 asynchronously mid-slot → an=8'hFF, seg=7'h7F, dp=1 without waiting for a clock edge. Also run with REFRESH_DIV=4, BLANK_CYC=3: exactly 1 lit clock per slot.
